mul_shift_add: RTL

// - Parametrised sequential multiplier: radix-2 shift-and-add, with start/busy/done handshake.
// - Takes both operands in parallel in one cycle.
// - Supports unsigned and two's-complement signed operands, selected per operation.
// - Optional early exit: finishes once the remaining multiplier is zero.
// - Standalone arithmetic unit for the multiplier datapath/controller family; controller and datapath are split.

---
 rtl/mul_pkg.sv | 12 +
 rtl/mul_shift_add_ctrl.sv | 50 +++++
 rtl/mul_shift_add.sv | 85 ++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier family: controller state encoding
// and the default operand width.
package mul_pkg;

   localparam int MUL_WIDTH = 16;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_CALC = 1'b1
   } state_t;

endpackage

// File: rtl/mul_shift_add_ctrl.sv
// Two-state controller for the shift-and-add multiplier: accepts start in IDLE,
// steps the datapath in CALC until term, then pulses done for one cycle.
module mul_shift_add_ctrl
   import mul_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic term,
   output logic ld,
   output logic step,
   output logic wr_prod,
   output logic busy,
   output logic done
);

   state_t state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state <= ST_CALC;
                  busy  <= 1'b1;
               end
            end
            ST_CALC: begin
               if (term) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Strobes are decoded from the current state so the datapath acts on the same edge.
   assign ld      = (state == ST_IDLE) && start;
   assign step    = (state == ST_CALC) && !term;
   assign wr_prod = (state == ST_CALC) && term;

endmodule

// File: rtl/mul_shift_add.sv
// Radix-2 shift-and-add multiplier with start/busy/done handshake; works on
// operand magnitudes and restores the sign of the product at write-back.
module mul_shift_add
   import mul_pkg::*;
#(
   parameter int WIDTH      = MUL_WIDTH,
   parameter int EARLY_EXIT = 1
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               signed_mode,
   input  logic [WIDTH-1:0]   a_in,
   input  logic [WIDTH-1:0]   b_in,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

   logic [2*WIDTH-1:0] ma;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   mb;
   logic [CNT_W-1:0]   cnt;
   logic               neg;
   logic               ld;
   logic               step;
   logic               wr_prod;
   logic               term;

   // The most negative value maps to 2^(WIDTH-1), which is exact as unsigned.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                  input logic sm);
      return (sm && v[WIDTH-1]) ? (~v + 1'b1) : v;
   endfunction

   function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] v,
                                                     input logic n);
      return n ? (~v + 1'b1) : v;
   endfunction

   assign term = (EARLY_EXIT != 0) ? (mb == '0) : (cnt == CNT_MAX);

   mul_shift_add_ctrl u_ctrl (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .term    (term),
      .ld      (ld),
      .step    (step),
      .wr_prod (wr_prod),
      .busy    (busy),
      .done    (done)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         ma      <= '0;
         mb      <= '0;
         acc     <= '0;
         cnt     <= '0;
         neg     <= 1'b0;
         product <= '0;
      end else begin
         if (ld) begin
            ma  <= {{WIDTH{1'b0}}, magnitude(a_in, signed_mode)};
            mb  <= magnitude(b_in, signed_mode);
            acc <= '0;
            cnt <= '0;
            neg <= signed_mode && (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
         end
         if (step) begin
            if (mb[0]) acc <= acc + ma;
            ma  <= ma << 1;
            mb  <= mb >> 1;
            cnt <= cnt + CNT_W'(1);
         end
         if (wr_prod) product <= apply_sign(acc, neg);
      end
   end

endmodule
